store_buffer: RTL and testbench
===============================

Name: store_buffer

Overview:
- Posted-write buffer between the mips32 core and exmemory, on the core's memory port.
- Core stores enter a DEPTH-entry FIFO in the cycle they are issued; the FIFO drains one word per cycle into exmemory whenever the core is not reading.
- Core reads return the youngest matching buffered store, otherwise memory data.
- No change to core or memory timing beyond one-cycle write posting.

Parameters:
- WIDTH, 32, data and address width in bits.
- DEPTH, 4, number of buffer entries; power of two, at least 2.
- PTRBITS, 2, pointer width; equals log2(DEPTH).

Ports:
- clk  input  1  system clock; all state updates on posedge.
- reset  input  1  asynchronous, active-low reset.
- cpu_memread  input  1  core read request; address on cpu_adr.
- cpu_memwrite  input  1  core store request, one word per asserted cycle.
- cpu_adr  input  WIDTH  core byte address; word-aligned, word index = cpu_adr[WIDTH-1:2].
- cpu_writedata  input  WIDTH  core store data.
- cpu_memdata  output  WIDTH  read data to core (combinational).
- mem_memwrite  output  1  write strobe to exmemory.
- mem_adr  output  WIDTH  address to exmemory.
- mem_writedata  output  WIDTH  data to exmemory.
- mem_memdata  input  WIDTH  exmemory combinational read data.
- buf_full  output  1  count == DEPTH.
- buf_empty  output  1  count == 0.
- overflow  output  1  sticky error: a store was dropped.

Behaviour:
- Reset (async, active-low): wr_ptr, rd_ptr, count cleared; overflow cleared; entry valid bits cleared; buf_empty=1, buf_full=0, mem_memwrite=0. Entry data is not reset. Reset mid-drain discards all pending stores.
- Drain condition: drain = !buf_empty && !cpu_memread.
- Memory port mux (combinational):
  - drain=1: mem_adr=head.adr, mem_writedata=head.data, mem_memwrite=1.
  - drain=0: mem_adr=cpu_adr, mem_writedata=0, mem_memwrite=0.
- Pop: head removed on the posedge where drain=1 (exmemory captures on the same edge).
- Push: on posedge with cpu_memwrite=1, {cpu_adr, cpu_writedata} is written at wr_ptr.
  - Accepted when count<DEPTH, or count==DEPTH with drain=1 (same-edge pop and push).
  - Otherwise the store is dropped and overflow is set to 1 until reset.
- Count update: count += push − pop. Pointers wrap modulo DEPTH.
- No same-cycle bypass: a store pushed into an empty buffer reaches memory no earlier than the next edge. Minimum latency from core store edge to memory update is 1 cycle.
- Priority: core read stalls the drain (reads never wait). Sustained reads with a full buffer make further stores overflow.
- Read forwarding: cpu_memdata = data of the youngest valid entry whose word index equals cpu_adr[WIDTH-1:2], else mem_memdata.
  - Youngest = closest to wr_ptr−1, searched backwards through count entries.
  - A store pushed on the same edge is not visible until after that edge.
- cpu_memwrite and cpu_memread together: the read uses the current buffer contents; the push happens at the edge as usual.
- Address wrap: comparison uses the full WIDTH-2 word-index bits; no aliasing.

Test Plan:
- Single store: reset released; store adr=252 data=13 at edge 1 -> buf_empty=0 after edge 1; mem_memwrite=1 with mem_adr=252 and mem_writedata=13 during the following cycle; RAM[63]=13 after edge 2; buf_empty=1.
- Fill and stall: hold cpu_memread=1; store adr 0,4,8,12 with data 1..4 -> buf_full=1. Fifth store to adr 16 -> dropped, overflow=1. Release read -> memory writes in order 1,2,3,4 on 4 consecutive edges.
- Full with simultaneous drain: buffer full, cpu_memread=0, store adr=16 data=5 -> accepted, overflow stays 0, count stays 4.
- Forwarding: store adr=8 data=7, then adr=8 data=9, hold cpu_memread=1 with cpu_adr=8 -> cpu_memdata=9. cpu_adr=12 -> cpu_memdata equals mem_memdata.
- Async reset mid-drain: 3 entries pending; assert reset between edges -> buf_empty=1 and mem_memwrite=0 immediately, overflow=0; no further memory writes after release.
- Integration: mips32 running fib32.dat through the buffer -> memory write of 13 to address 252; overflow remains 0.

Source files
------------

// File: rtl/store_buffer.sv
// store_buffer: posted-write buffer on the core's memory port.
//
// Core stores are captured into a DEPTH-entry FIFO on the edge they are issued.
// The FIFO drains one word per cycle into exmemory whenever the core is not reading.
// Core reads are forwarded from the youngest matching buffered store, otherwise
// they see exmemory's combinational read data.
//
// Ports:
//   clk, reset        clock; asynchronous active-low reset
//   cpu_memread       core read request (address on cpu_adr)
//   cpu_memwrite      core store request, one word per asserted cycle
//   cpu_adr           core byte address (word index = cpu_adr[WIDTH-1:2])
//   cpu_writedata     core store data
//   cpu_memdata       read data returned to the core (combinational)
//   mem_memwrite      write strobe to exmemory (combinational)
//   mem_adr           address to exmemory (combinational)
//   mem_writedata     write data to exmemory (combinational)
//   mem_memdata       exmemory combinational read data
//   buf_full          buffer holds DEPTH entries
//   buf_empty         buffer holds no entries
//   overflow          sticky: a store was dropped since reset
module store_buffer #(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned PTRBITS = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cpu_memread,
    input  logic             cpu_memwrite,
    input  logic [WIDTH-1:0] cpu_adr,
    input  logic [WIDTH-1:0] cpu_writedata,
    output logic [WIDTH-1:0] cpu_memdata,
    output logic             mem_memwrite,
    output logic [WIDTH-1:0] mem_adr,
    output logic [WIDTH-1:0] mem_writedata,
    input  logic [WIDTH-1:0] mem_memdata,
    output logic             buf_full,
    output logic             buf_empty,
    output logic             overflow
);

    // One extra bit so count can represent DEPTH itself
    localparam int unsigned CNTBITS = PTRBITS + 1;

    typedef struct packed {
        logic [WIDTH-1:0] adr;
        logic [WIDTH-1:0] data;
    } entry_t;

    entry_t              entries [DEPTH];
    logic [DEPTH-1:0]    valid;
    logic [DEPTH-1:0]    valid_next;
    logic [PTRBITS-1:0]  wr_ptr;
    logic [PTRBITS-1:0]  rd_ptr;
    logic [CNTBITS-1:0]  count;
    logic                overflow_q;

    logic                drain;
    logic                has_room;
    logic                push;
    logic                pop;
    entry_t              head;

    logic                fwd_hit;
    logic [WIDTH-1:0]    fwd_data;
    logic [PTRBITS-1:0]  fwd_idx;

    // Occupancy flags and transfer decisions
    assign buf_empty = (count == CNTBITS'(0));
    assign buf_full  = (count == CNTBITS'(DEPTH));
    assign overflow  = overflow_q;

    // Reads always win the memory port; the drain waits for an idle cycle
    assign drain    = !buf_empty && !cpu_memread;
    assign pop      = drain;
    // A full buffer still accepts a store when the head leaves on the same edge
    assign has_room = !buf_full || drain;
    assign push     = cpu_memwrite && has_room;
    assign head     = entries[rd_ptr];

    // Memory port mux: head entry while draining, otherwise the core's address
    always_comb begin
        mem_memwrite  = 1'b0;
        mem_adr       = cpu_adr;
        mem_writedata = '0;
        if (drain) begin
            mem_memwrite  = 1'b1;
            mem_adr       = head.adr;
            mem_writedata = head.data;
        end
    end

    // Valid bits: clear the popped slot first so a same-slot push wins when full
    always_comb begin
        valid_next = valid;
        if (pop) begin
            valid_next[rd_ptr] = 1'b0;
        end
        if (push) begin
            valid_next[wr_ptr] = 1'b1;
        end
    end

    // Pointers, occupancy, valid bits and sticky overflow
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            valid      <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTRBITS'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTRBITS'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNTBITS'(1);
                2'b01:   count <= count - CNTBITS'(1);
                default: count <= count;
            endcase
            if (cpu_memwrite && !has_room) begin
                overflow_q <= 1'b1;
            end
            valid <= valid_next;
        end
    end

    // Entry payload storage; contents are qualified by valid/count, so no reset
    always_ff @(posedge clk) begin
        if (push) begin
            entries[wr_ptr] <= '{adr: cpu_adr, data: cpu_writedata};
        end
    end

    // Forwarding: walk back from the newest entry, first word-index match wins
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = '0;
        fwd_idx  = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            fwd_idx = wr_ptr - PTRBITS'(1) - PTRBITS'(i);
            if (!fwd_hit && (CNTBITS'(i) < count) && valid[fwd_idx] &&
                (entries[fwd_idx].adr[WIDTH-1:2] == cpu_adr[WIDTH-1:2])) begin
                fwd_hit  = 1'b1;
                fwd_data = entries[fwd_idx].data;
            end
        end
    end

    assign cpu_memdata = fwd_hit ? fwd_data : mem_memdata;

endmodule

// File: tb/tb_store_buffer.sv
// tb_store_buffer: directed stimulus for store_buffer with an exmemory stand-in,
// a queue-based reference model checked every cycle, and literal spot checks.
module tb_store_buffer;

    localparam int unsigned WIDTH = 32;
    localparam int unsigned DEPTH = 4;

    logic             clk;
    logic             reset;
    logic             cpu_memread;
    logic             cpu_memwrite;
    logic [WIDTH-1:0] cpu_adr;
    logic [WIDTH-1:0] cpu_writedata;
    logic [WIDTH-1:0] cpu_memdata;
    logic             mem_memwrite;
    logic [WIDTH-1:0] mem_adr;
    logic [WIDTH-1:0] mem_writedata;
    logic [WIDTH-1:0] mem_memdata;
    logic             buf_full;
    logic             buf_empty;
    logic             overflow;

    store_buffer #(.WIDTH(WIDTH), .DEPTH(DEPTH), .PTRBITS(2)) dut (
        .clk           (clk),
        .reset         (reset),
        .cpu_memread   (cpu_memread),
        .cpu_memwrite  (cpu_memwrite),
        .cpu_adr       (cpu_adr),
        .cpu_writedata (cpu_writedata),
        .cpu_memdata   (cpu_memdata),
        .mem_memwrite  (mem_memwrite),
        .mem_adr       (mem_adr),
        .mem_writedata (mem_writedata),
        .mem_memdata   (mem_memdata),
        .buf_full      (buf_full),
        .buf_empty     (buf_empty),
        .overflow      (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    // exmemory stand-in: 256 words, combinational read, write on posedge
    logic [31:0] ram [256];
    logic [31:0] log_adr  [$];
    logic [31:0] log_data [$];

    assign mem_memdata = ram[mem_adr[9:2]];

    always @(posedge clk) begin
        if (mem_memwrite) begin
            ram[mem_adr[9:2]] <= mem_writedata;
            log_adr.push_back(mem_adr);
            log_data.push_back(mem_writedata);
        end
    end

    // Reference model: FIFO of pending stores plus its own view of memory
    typedef struct {
        logic [31:0] adr;
        logic [31:0] data;
    } st_t;

    st_t         mq [$];
    logic        m_ovf;
    logic [31:0] model_mem [256];

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            mq.delete();
            m_ovf = 1'b0;
        end else begin
            int   sz;
            logic d;
            st_t  e;
            logic [31:0] a;
            sz = mq.size();
            d  = (sz != 0) && !cpu_memread;
            if (d) begin
                e = mq.pop_front();
                a = e.adr;
                model_mem[a[9:2]] = e.data;
            end
            if (cpu_memwrite) begin
                if (sz < DEPTH || d) begin
                    e.adr  = cpu_adr;
                    e.data = cpu_writedata;
                    mq.push_back(e);
                end else begin
                    m_ovf = 1'b1;
                end
            end
        end
    end

    // Per-cycle comparison against the model, away from the active edge
    always @(negedge clk) begin
        int   sz;
        logic d;
        logic [31:0] exp_rd;
        logic [31:0] a;
        logic found;
        sz = mq.size();
        d  = (sz != 0) && !cpu_memread;
        check("m_empty", 32'(buf_empty), 32'(sz == 0));
        check("m_full", 32'(buf_full), 32'(sz == DEPTH));
        check("m_ovf", 32'(overflow), 32'(m_ovf));
        check("m_memwrite", 32'(mem_memwrite), 32'(d));
        check("m_adr", mem_adr, d ? mq[0].adr : cpu_adr);
        check("m_wdata", mem_writedata, d ? mq[0].data : 32'd0);
        if (cpu_memread) begin
            a      = cpu_adr;
            exp_rd = model_mem[a[9:2]];
            found  = 1'b0;
            for (int k = sz - 1; k >= 0; k--) begin
                if (!found && mq[k].adr[31:2] == cpu_adr[31:2]) begin
                    found  = 1'b1;
                    exp_rd = mq[k].data;
                end
            end
            check("m_rdata", cpu_memdata, exp_rd);
        end
    end

    task automatic drive(input logic rd, input logic wr, input logic [31:0] adr, input logic [31:0] data);
        cpu_memread   = rd;
        cpu_memwrite  = wr;
        cpu_adr       = adr;
        cpu_writedata = data;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            ram[i]       = 32'(i * 16 + 256);
            model_mem[i] = 32'(i * 16 + 256);
        end
        reset = 1'b0;
        drive(1'b0, 1'b0, 32'd0, 32'd0);
        step();
        step();
        check("rst_empty", 32'(buf_empty), 32'd1);
        check("rst_full", 32'(buf_full), 32'd0);
        check("rst_ovf", 32'(overflow), 32'd0);
        check("rst_memwrite", 32'(mem_memwrite), 32'd0);
        reset = 1'b1;
        step();

        // Single store: posted on edge 1, written to memory on edge 2
        drive(1'b0, 1'b1, 32'd252, 32'd13);
        step();
        drive(1'b0, 1'b0, 32'd0, 32'd0);
        check("t1_empty", 32'(buf_empty), 32'd0);
        check("t1_memwrite", 32'(mem_memwrite), 32'd1);
        check("t1_adr", mem_adr, 32'd252);
        check("t1_wdata", mem_writedata, 32'd13);
        step();
        check("t1_ram63", ram[63], 32'd13);
        check("t1_empty2", 32'(buf_empty), 32'd1);

        // Fill while reads stall the drain, then overflow
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'b1, 32'(4 * i), 32'(i + 1));
            step();
        end
        check("t2_full", 32'(buf_full), 32'd1);
        check("t2_ovf0", 32'(overflow), 32'd0);
        drive(1'b1, 1'b1, 32'd16, 32'd99);
        step();
        check("t2_ovf1", 32'(overflow), 32'd1);
        check("t2_full2", 32'(buf_full), 32'd1);
        drive(1'b1, 1'b0, 32'd8, 32'd0);
        #1;
        check("t2_fwd8", cpu_memdata, 32'd3);
        log_adr.delete();
        log_data.delete();
        drive(1'b0, 1'b0, 32'd0, 32'd0);
        for (int i = 0; i < 4; i++) begin
            step();
        end
        check("t2_nwrites", 32'(log_data.size()), 32'd4);
        if (log_data.size() == 4) begin
            for (int i = 0; i < 4; i++) begin
                check("t2_order_data", log_data[i], 32'(i + 1));
                check("t2_order_adr", log_adr[i], 32'(4 * i));
            end
        end
        check("t2_empty", 32'(buf_empty), 32'd1);

        // Clear sticky overflow
        reset = 1'b0;
        step();
        reset = 1'b1;
        check("t3_ovf_cleared", 32'(overflow), 32'd0);

        // Full buffer with a same-edge drain accepts the store
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'b1, 32'(32 + 4 * i), 32'(21 + i));
            step();
        end
        drive(1'b0, 1'b1, 32'd16, 32'd5);
        step();
        drive(1'b0, 1'b0, 32'd0, 32'd0);
        check("t3_full", 32'(buf_full), 32'd1);
        check("t3_ovf", 32'(overflow), 32'd0);
        check("t3_head", mem_adr, 32'd36);
        for (int i = 0; i < 4; i++) begin
            step();
        end
        check("t3_empty", 32'(buf_empty), 32'd1);
        check("t3_ram4", ram[4], 32'd5);
        check("t3_ram8", ram[8], 32'd21);

        // Forwarding: youngest match wins, full word index compared
        drive(1'b1, 1'b1, 32'd8, 32'd7);
        step();
        drive(1'b1, 1'b1, 32'd8, 32'd9);
        step();
        drive(1'b1, 1'b1, 32'h8000_0008, 32'd55);
        step();
        drive(1'b1, 1'b0, 32'd8, 32'd0);
        #1;
        check("t4_fwd8", cpu_memdata, 32'd9);
        drive(1'b1, 1'b0, 32'd12, 32'd0);
        #1;
        check("t4_nofwd12", cpu_memdata, 32'd4);
        check("t4_nofwd12_mem", cpu_memdata, mem_memdata);
        drive(1'b1, 1'b0, 32'h8000_0008, 32'd0);
        #1;
        check("t4_fwd_hi", cpu_memdata, 32'd55);
        drive(1'b0, 1'b0, 32'd0, 32'd0);
        for (int i = 0; i < 3; i++) begin
            step();
        end
        check("t4_empty", 32'(buf_empty), 32'd1);
        check("t4_ram2", ram[2], 32'd55);

        // Async reset mid-drain discards pending stores
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b1, 32'(100 + 4 * i), 32'(31 + i));
            step();
        end
        drive(1'b0, 1'b0, 32'd0, 32'd0);
        #1;
        check("t5_draining", 32'(mem_memwrite), 32'd1);
        #1;
        reset = 1'b0;
        #1;
        check("t5_empty", 32'(buf_empty), 32'd1);
        check("t5_memwrite", 32'(mem_memwrite), 32'd0);
        check("t5_ovf", 32'(overflow), 32'd0);
        step();
        reset = 1'b1;
        log_adr.delete();
        log_data.delete();
        for (int i = 0; i < 4; i++) begin
            step();
        end
        check("t5_nowrites", 32'(log_data.size()), 32'd0);
        check("t5_ram25", ram[25], 32'd656);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
